// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified-memory arbiter.
//   state_t  : arbiter FSM states (IDLE, ACCESS, RESP)
//   gnt_t    : grant owner (GNT_IF = instruction fetch, GNT_D = data)
//   DEF_*    : default widths / latency used by mem_arbiter
//   cnt_width: width of the access-latency down-counter
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_MEM_LAT = 2;
  localparam int STATS_W     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

  // The counter only ever holds MEM_LAT-1 down to 0; keep at least one bit.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_stats.sv
// -----------------------------------------------------------------------------
// mem_arb_stats
// Two saturating 32-bit wait counters, one per requester. A counter advances in
// every cycle where its request is high and its ready pulse is low.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   if_req, if_ready      fetch request level / completion pulse
//   d_req, d_ready        data request level (read|write) / completion pulse
//   if_wait_cnt           fetch wait-cycle count (saturates at all-ones)
//   d_wait_cnt            data wait-cycle count (saturates at all-ones)
// -----------------------------------------------------------------------------
module mem_arb_stats
  import mem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic               if_ready,
  input  logic               d_req,
  input  logic               d_ready,
  output logic [STATS_W-1:0] if_wait_cnt,
  output logic [STATS_W-1:0] d_wait_cnt
);

  // Index 0 = fetch, index 1 = data.
  logic [1:0] w_wait;

  assign w_wait[0] = if_req & ~if_ready;
  assign w_wait[1] = d_req  & ~d_ready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ctr
      logic [STATS_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (w_wait[gi] && (r_cnt != '1)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  assign if_wait_cnt = g_ctr[0].r_cnt;
  assign d_wait_cnt  = g_ctr[1].r_cnt;

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported, fixed-latency memory between instruction fetch and
// the data (MEM) stage. Data wins arbitration unless the previous grant was
// also data and fetch is waiting, so grants alternate under contention.
// Each access: IDLE (grant) -> ACCESS (MEM_LAT cycles of mem_en) -> RESP
// (one-cycle ready pulse to the granted requester) -> IDLE.
//
// Optional feature: define MEM_ARB_STATS_EN to add if_wait_cnt / d_wait_cnt
// (saturating wait-cycle counters, see mem_arb_stats).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req, if_addr               fetch request level and byte address
//   if_rdata, if_ready            fetched word, one-cycle completion pulse
//   d_read, d_write               data read / write request levels
//   d_addr, d_wdata               data address and store data
//   d_rdata, d_ready              load word, one-cycle completion pulse
//   mem_en, mem_we                memory enable / write enable
//   mem_addr, mem_wdata           memory address / write data
//   mem_rdata                     memory read data (valid in last mem_en cycle)
//   if_wait_cnt, d_wait_cnt       (MEM_ARB_STATS_EN only) wait-cycle counters
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = DEF_MEM_LAT
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic [DATA_W-1:0]  if_rdata,
  output logic               if_ready,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  output logic [DATA_W-1:0]  d_rdata,
  output logic               d_ready,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] if_wait_cnt,
  output logic [STATS_W-1:0] d_wait_cnt
`endif
);

  localparam int              CNT_W    = cnt_width(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  // State and datapath registers
  state_t              r_state,     w_state_next;
  logic [CNT_W-1:0]    r_cnt,       w_cnt_next;
  gnt_t                r_gnt,       w_gnt_next;
  gnt_t                r_last_gnt,  w_last_gnt_next;
  logic                r_mem_en,    w_mem_en_next;
  logic                r_mem_we,    w_mem_we_next;
  logic [ADDR_W-1:0]   r_mem_addr,  w_mem_addr_next;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_next;
  logic [DATA_W-1:0]   r_if_rdata,  w_if_rdata_next;
  logic [DATA_W-1:0]   r_d_rdata,   w_d_rdata_next;

  logic                w_d_req;
  gnt_t                w_pick;

  // A read+write collision is a write; either level is a data request.
  assign w_d_req = d_read | d_write;

  // Data first, except when data just had the bus and fetch is waiting.
  always_comb begin
    w_pick = GNT_IF;
    if (w_d_req && !(if_req && (r_last_gnt == GNT_D))) begin
      w_pick = GNT_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_gnt       <= GNT_IF;
      r_last_gnt  <= GNT_IF;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_gnt       <= w_gnt_next;
      r_last_gnt  <= w_last_gnt_next;
      r_mem_en    <= w_mem_en_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_if_rdata  <= w_if_rdata_next;
      r_d_rdata   <= w_d_rdata_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_gnt_next       = r_gnt;
    w_last_gnt_next  = r_last_gnt;
    w_mem_en_next    = r_mem_en;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_if_rdata_next  = r_if_rdata;
    w_d_rdata_next   = r_d_rdata;

    unique case (r_state)
      IDLE: begin
        if (if_req || w_d_req) begin
          w_gnt_next      = w_pick;
          w_last_gnt_next = w_pick;
          w_mem_en_next   = 1'b1;
          w_cnt_next      = CNT_LOAD;
          w_state_next    = ACCESS;
          if (w_pick == GNT_D) begin
            w_mem_we_next    = d_write;
            w_mem_addr_next  = d_addr;
            w_mem_wdata_next = d_wdata;
          end else begin
            w_mem_we_next    = 1'b0;
            w_mem_addr_next  = if_addr;
          end
        end
      end

      ACCESS: begin
        if (r_cnt == '0) begin
          // Last enabled cycle: mem_rdata is valid now.
          w_mem_en_next = 1'b0;
          w_mem_we_next = 1'b0;
          w_state_next  = RESP;
          if (r_gnt == GNT_IF) begin
            w_if_rdata_next = mem_rdata;
          end else if (!r_mem_we) begin
            w_d_rdata_next = mem_rdata;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end

      RESP: begin
        w_state_next = IDLE;
      end

      default: begin
        w_state_next  = IDLE;
        w_mem_en_next = 1'b0;
        w_mem_we_next = 1'b0;
      end
    endcase
  end

  // Ready is high exactly while the FSM sits in RESP for the granted side.
  assign if_ready  = (r_state == RESP) && (r_gnt == GNT_IF);
  assign d_ready   = (r_state == RESP) && (r_gnt == GNT_D);
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

`ifdef MEM_ARB_STATS_EN
  mem_arb_stats u_stats (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_ready    (if_ready),
    .d_req       (w_d_req),
    .d_ready     (d_ready),
    .if_wait_cnt (if_wait_cnt),
    .d_wait_cnt  (d_wait_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed stimulus against two arbiters (MEM_LAT=2 and MEM_LAT=1), each with
// its own behavioural memory. Stimulus pushes the expected ready pulse (port,
// data, cycle) into a queue; a monitor pops and compares on every ready pulse.
// Define MEM_ARB_STATS_EN to also check the wait counters.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst;

  // DUT 0 (MEM_LAT = 2)
  logic        if_req, d_read, d_write, if_ready, d_ready, mem_en, mem_we;
  logic [31:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  // DUT 1 (MEM_LAT = 1)
  logic        if_req_1, d_read_1, d_write_1, if_ready_1, d_ready_1, mem_en_1, mem_we_1;
  logic [31:0] if_addr_1, d_addr_1, d_wdata_1, if_rdata_1, d_rdata_1;
  logic [31:0] mem_addr_1, mem_wdata_1, mem_rdata_1;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] if_wait_cnt, d_wait_cnt, if_wait_cnt_1, d_wait_cnt_1;
`endif

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
    , .if_wait_cnt(if_wait_cnt), .d_wait_cnt(d_wait_cnt)
`endif
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_1 (
    .clk(clk), .rst(rst),
    .if_req(if_req_1), .if_addr(if_addr_1), .if_rdata(if_rdata_1), .if_ready(if_ready_1),
    .d_read(d_read_1), .d_write(d_write_1), .d_addr(d_addr_1), .d_wdata(d_wdata_1),
    .d_rdata(d_rdata_1), .d_ready(d_ready_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1)
`ifdef MEM_ARB_STATS_EN
    , .if_wait_cnt(if_wait_cnt_1), .d_wait_cnt(d_wait_cnt_1)
`endif
  );

  // Behavioural memories: combinational read while enabled, write on the edge.
  logic [31:0] mem   [256];
  logic [31:0] mem_1 [256];
  logic [7:0]  idx, idx_1;
  assign idx         = 8'(mem_addr >> 2);
  assign idx_1       = 8'(mem_addr_1 >> 2);
  assign mem_rdata   = mem_en   ? mem[idx]     : 32'h0;
  assign mem_rdata_1 = mem_en_1 ? mem_1[idx_1] : 32'h0;
  always @(posedge clk) begin
    if (mem_en   && mem_we)   mem[idx]     <= mem_wdata;
    if (mem_en_1 && mem_we_1) mem_1[idx_1] <= mem_wdata_1;
  end

  // Scoreboard
  typedef struct {
    int          dut;
    logic        is_d;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int dut, input logic is_d, input logic [31:0] data, input int at);
    exp_t e;
    e.dut = dut; e.is_d = is_d; e.data = data; e.at = at;
    sb_q.push_back(e);
  endtask

  task automatic take(input int dut, input logic is_d, input logic [31:0] data);
    exp_t e;
    $display("resp dut%0d %s data=%h cycle=%0d", dut, is_d ? "D " : "IF", data, cyc);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ready: got ready on dut%0d expected none (cycle %0d)", dut, cyc);
    end else begin
      e = sb_q.pop_front();
      chk("resp_dut",   32'(dut),  32'(e.dut));
      chk("resp_port",  32'(is_d), 32'(e.is_d));
      chk("resp_cycle", 32'(cyc),  32'(e.at));
      chk("resp_data",  data,      e.data);
    end
  endtask

  // Monitor: sampled on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (if_ready || d_ready)     take(0, d_ready,   d_ready   ? d_rdata   : if_rdata);
    if (if_ready_1 || d_ready_1) take(1, d_ready_1, d_ready_1 ? d_rdata_1 : if_rdata_1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int t;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 32'h0;
      mem_1[i] = 32'h0;
    end
    mem[8'h10] = 32'h8C010004;   // 0x40
    mem[8'h11] = 32'h11111111;   // 0x44
    mem[8'h40] = 32'h22222222;   // 0x100
    mem[8'h41] = 32'h33333333;   // 0x104

    rst = 1'b1;
    if_req = 0; if_addr = 0; d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0;
    if_req_1 = 0; if_addr_1 = 0; d_read_1 = 0; d_write_1 = 0; d_addr_1 = 0; d_wdata_1 = 0;

    // Reset state
    step(3);
    chk("reset_ctrl", {30'd0, mem_en, mem_we}, 32'd0);
    chk("reset_ready", {30'd0, if_ready, d_ready}, 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_if_rdata", if_rdata, 32'd0);
    chk("reset_d_rdata", d_rdata, 32'd0);
    rst = 1'b0;
    step(1);

    // Single fetch
    t = cyc;
    if_req = 1; if_addr = 32'h40;
    push(0, 1'b0, 32'h8C010004, t + 3);
    step(1);
    chk("fetch_en_c1", {31'd0, mem_en}, 32'd1);
    chk("fetch_addr", mem_addr, 32'h40);
    chk("fetch_we", {31'd0, mem_we}, 32'd0);
    step(1);
    chk("fetch_en_c2", {31'd0, mem_en}, 32'd1);
    step(1);
    chk("fetch_en_c3", {31'd0, mem_en}, 32'd0);
    step(1);
    if_req = 0;
    step(1);

    // Simultaneous requests: data served first
    t = cyc;
    if_req = 1; if_addr = 32'h44; d_read = 1; d_addr = 32'h100;
    push(0, 1'b1, 32'h22222222, t + 3);
    push(0, 1'b0, 32'h11111111, t + 7);
    step(1);
    chk("simul_first_addr", mem_addr, 32'h100);
    step(3);
    d_read = 0;
    step(1);
    chk("simul_second_addr", mem_addr, 32'h44);
    step(3);
    if_req = 0;
    step(1);

    // Both held with fresh addresses: grants alternate D, IF, D, IF
    t = cyc;
    if_req = 1; if_addr = 32'h40; d_read = 1; d_addr = 32'h100;
    push(0, 1'b1, 32'h22222222, t + 3);
    push(0, 1'b0, 32'h8C010004, t + 7);
    push(0, 1'b1, 32'h33333333, t + 11);
    push(0, 1'b0, 32'h11111111, t + 15);
    step(4);
    d_addr = 32'h104;
    step(4);
    if_addr = 32'h44;
    step(4);
    d_read = 0;
    step(4);
    if_req = 0;
    step(1);

    // Store then load
    t = cyc;
    d_write = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
    push(0, 1'b1, 32'h33333333, t + 3);   // d_rdata unchanged by the write
    step(1);
    chk("store_we_c1", {30'd0, mem_en, mem_we}, 32'd3);
    chk("store_addr", mem_addr, 32'h200);
    chk("store_wdata", mem_wdata, 32'hDEADBEEF);
    step(1);
    chk("store_we_c2", {30'd0, mem_en, mem_we}, 32'd3);
    step(1);
    chk("store_we_c3", {30'd0, mem_en, mem_we}, 32'd0);
    step(1);
    d_write = 0; d_read = 1;
    push(0, 1'b1, 32'hDEADBEEF, t + 7);
    step(4);
    d_read = 0;
    step(1);

    // Reset during the second mem_en cycle
    t = cyc;
    if_req = 1; if_addr = 32'h44;
    step(1);
    chk("rstmid_en_c1", {31'd0, mem_en}, 32'd1);
    step(1);
    rst = 1'b1;
    step(1);
    chk("rstmid_ctrl", {28'd0, mem_en, mem_we, if_ready, d_ready}, 32'd0);
    chk("rstmid_addr", mem_addr, 32'd0);
    chk("rstmid_d_rdata", d_rdata, 32'd0);
    chk("rstmid_if_rdata", if_rdata, 32'd0);
    rst = 1'b0;
    push(0, 1'b0, 32'h11111111, t + 6);
    step(4);
`ifdef MEM_ARB_STATS_EN
    chk("stats_if_after_rst", if_wait_cnt, 32'd3);
    chk("stats_d_after_rst", d_wait_cnt, 32'd0);
`endif
    if_req = 0;
    step(1);

    // Fetch held behind one data grant (last grant reset to fetch)
    t = cyc;
    if_req = 1; if_addr = 32'h40; d_read = 1; d_addr = 32'h100;
    push(0, 1'b1, 32'h22222222, t + 3);
    push(0, 1'b0, 32'h8C010004, t + 7);
    step(4);
    d_read = 0;
    step(4);
`ifdef MEM_ARB_STATS_EN
    chk("stats_if_wait", if_wait_cnt, 32'd10);
    chk("stats_d_wait", d_wait_cnt, 32'd3);
`endif
    if_req = 0;
    step(1);

    // MEM_LAT = 1 with read and write both asserted: a write
    t = cyc;
    d_read_1 = 1; d_write_1 = 1; d_addr_1 = 32'h10; d_wdata_1 = 32'hCAFEF00D;
    push(1, 1'b1, 32'h00000000, t + 2);
    step(1);
    chk("lat1_en_we", {30'd0, mem_en_1, mem_we_1}, 32'd3);
    chk("lat1_wdata", mem_wdata_1, 32'hCAFEF00D);
    step(1);
    chk("lat1_en_done", {31'd0, mem_en_1}, 32'd0);
    step(1);
    d_write_1 = 0;
    push(1, 1'b1, 32'hCAFEF00D, t + 5);
    step(3);
    d_read_1 = 0;
    step(2);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
